// File: rtl/geo_cmd_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : geo_cmd_unpacker
// Description : Assembles 16-bit geometry command words (header plus 0..6
//               argument words) from a FWFT FIFO into one parallel command
//               on a valid/ready port. Drives the FIFO shift_out itself.
//               Optional macro GEO_CMD_TIMEOUT_EN enables dropping a partial
//               command after TIMEOUT_CYCLES consecutive empty-FIFO cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module geo_cmd_unpacker #(
    parameter int COORD_BITS     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [15:0]             in_data,
    output logic                    in_shift,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [3:0]              cmd_op,
    output logic [11:0]             cmd_param,
    output logic [6*COORD_BITS-1:0] cmd_args,
    output logic                    cmd_bad,
    output logic                    cmd_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARGS = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_op;
    logic [11:0]           r_param;
    logic [COORD_BITS-1:0] r_args [6];
    logic                  r_bad;
    logic                  r_valid;
    logic [2:0]            r_remain;
    logic [2:0]            r_slot;

    logic                  w_take_hdr;
    logic                  w_take_arg;
    logic [2:0]            w_hdr_cnt;

`ifdef GEO_CMD_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  r_timeout;
`endif

    // Number of argument words that follow a header with the given opcode.
    function automatic logic [2:0] f_arg_count(input logic [3:0] op);
        case (op)
            4'd2:       f_arg_count = 3'd2;
            4'd3, 4'd4: f_arg_count = 3'd4;
            4'd5:       f_arg_count = 3'd6;
            default:    f_arg_count = 3'd0;
        endcase
    endfunction

    // A header is taken when idle, or when the held command leaves this cycle.
    // in_data is deliberately kept out of the in_shift cone.
    assign w_take_hdr = in_valid && ((r_state == ST_IDLE) ||
                                     ((r_state == ST_OUT) && cmd_ready));
    assign w_take_arg = in_valid && (r_state == ST_ARGS);
    assign in_shift   = w_take_hdr || w_take_arg;
    assign w_hdr_cnt  = f_arg_count(in_data[15:12]);

    // Command assembly state machine with registered command outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_param  <= '0;
            r_bad    <= 1'b0;
            r_valid  <= 1'b0;
            r_remain <= '0;
            r_slot   <= '0;
            for (int i = 0; i < 6; i++) begin
                r_args[i] <= '0;
            end
`ifdef GEO_CMD_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef GEO_CMD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_ARGS: begin
                    if (w_take_arg) begin
                        r_args[r_slot] <= in_data[COORD_BITS-1:0];
                        r_slot         <= r_slot + 3'd1;
                        r_remain       <= r_remain - 3'd1;
`ifdef GEO_CMD_TIMEOUT_EN
                        r_tmo_cnt      <= '0;
`endif
                        if (r_remain == 3'd1) begin
                            r_state <= ST_OUT;
                            r_valid <= 1'b1;
                        end
                    end
`ifdef GEO_CMD_TIMEOUT_EN
                    // The FIFO has run dry too long: abandon the partial command.
                    else if (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_OUT: begin
                    if (cmd_ready && !in_valid) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Header decode; in OUT this overlaps the handoff of the old command.
            if (w_take_hdr) begin
                r_op     <= in_data[15:12];
                r_param  <= in_data[11:0];
                r_bad    <= (in_data[15:12] > 4'd5);
                r_slot   <= '0;
                r_remain <= w_hdr_cnt;
                for (int i = 0; i < 6; i++) begin
                    r_args[i] <= '0;
                end
`ifdef GEO_CMD_TIMEOUT_EN
                r_tmo_cnt <= '0;
`endif
                if (w_hdr_cnt != 3'd0) begin
                    r_state <= ST_ARGS;
                    r_valid <= 1'b0;
                end else begin
                    r_state <= ST_OUT;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign cmd_valid = r_valid;
    assign cmd_op    = r_op;
    assign cmd_param = r_param;
    assign cmd_bad   = r_bad;

    generate
        for (genvar k = 0; k < 6; k++) begin : g_args
            assign cmd_args[k*COORD_BITS +: COORD_BITS] = r_args[k];
        end
    endgenerate

`ifdef GEO_CMD_TIMEOUT_EN
    assign cmd_timeout = r_timeout;
`else
    assign cmd_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_geo_cmd_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_geo_cmd_unpacker
// Description : Scoreboard bench for geo_cmd_unpacker. Expected commands are
//               queued as stimulus is issued; a monitor pops and compares on
//               every accepted command. Honours GEO_CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_geo_cmd_unpacker;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_shift;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_param;
    logic [71:0] cmd_args;
    logic        cmd_bad;
    logic        cmd_timeout;

    geo_cmd_unpacker #(.COORD_BITS(12), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_shift(in_shift), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_param(cmd_param), .cmd_args(cmd_args),
        .cmd_bad(cmd_bad), .cmd_timeout(cmd_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] param;
        logic [71:0] args;
        logic        bad;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] mk_args(input logic [11:0] a0, a1, a2, a3, a4, a5);
        mk_args = {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic void expect_cmd(input logic [3:0] op, input logic [11:0] param,
                                       input logic [71:0] args, input logic bad);
        exp_t e;
        e.op = op; e.param = param; e.args = args; e.bad = bad;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted command against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        n_total++;
        if (in_shift && !in_valid) begin
            n_bad++;
            $display("FAIL shift_without_valid: in_shift=1 in_valid=0 at cycle %0d", cyc);
        end
        if (cmd_valid && cmd_ready && !reset) begin
            acc_cyc_q.push_back(cyc);
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_cmd: got op=%h param=%h args=%h bad=%b, expected none",
                         cmd_op, cmd_param, cmd_args, cmd_bad);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cmd_op !== e.op || cmd_param !== e.param ||
                    cmd_args !== e.args || cmd_bad !== e.bad) begin
                    n_bad++;
                    $display("FAIL cmd: got op=%h param=%h args=%h bad=%b expected op=%h param=%h args=%h bad=%b",
                             cmd_op, cmd_param, cmd_args, cmd_bad, e.op, e.param, e.args, e.bad);
                end
            end
        end
    end

    // Present one word and hold it until the DUT shifts it out (bounded).
    task automatic push_word(input logic [15:0] w);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            #1;
            if (in_shift) begin
                done = 1'b1;
                @(posedge clk);
            end
        end
        n_total++;
        if (!done) begin
            n_bad++;
            $display("FAIL push_word: word %h not consumed, expected consumption within 64 cycles", w);
        end
    endtask

    // One cycle with the FIFO empty and the given ready level.
    task automatic nd(input logic rdy);
        @(negedge clk);
        in_valid  = 1'b0;
        cmd_ready = rdy;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   cmd_valid,   1'b0);
        chk({tag, "_op"},      cmd_op,      4'h0);
        chk({tag, "_param"},   cmd_param,   12'h0);
        chk({tag, "_args"},    cmd_args,    72'h0);
        chk({tag, "_bad"},     cmd_bad,     1'b0);
        chk({tag, "_timeout"}, cmd_timeout, 1'b0);
        chk({tag, "_shift"},   in_shift,    1'b0);
    endtask

    initial begin
        logic [3:0]  s_op;
        logic [11:0] s_param;
        logic [71:0] s_args;
        int pulses;
        int hit;

        reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; cmd_ready = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // PLOT with back-to-back words; valid one cycle after the last word.
        expect_cmd(4'd2, 12'h123, mk_args(12'h010, 12'h020, 0, 0, 0, 0), 1'b0);
        push_word(16'h2123); push_word(16'h0010); push_word(16'h0020);
        nd(1'b1); #1;
        chk("plot_latency_valid", cmd_valid, 1'b1);

        // TRI: upper nibble of each argument stripped.
        nd(1'b1);
        expect_cmd(4'd5, 12'h000, mk_args(12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006), 1'b0);
        push_word(16'h5000);
        for (int i = 1; i <= 6; i++) push_word(16'hF000 | 16'(i));
        nd(1'b1); #1;
        chk("tri_latency_valid", cmd_valid, 1'b1);

        // Backpressure: command held while the next header waits in the FIFO.
        nd(1'b0);
        expect_cmd(4'd2, 12'hAAA, mk_args(12'h001, 12'h002, 0, 0, 0, 0), 1'b0);
        push_word(16'h2AAA); push_word(16'h0001); push_word(16'h0002);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h1555;
        #1;
        s_op = cmd_op; s_param = cmd_param; s_args = cmd_args;
        chk("hold_valid", cmd_valid, 1'b1);
        chk("hold_op_snapshot", s_op, 4'd2);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            chk("hold_shift", in_shift, 1'b0);
            chk("hold_stable", {cmd_valid, cmd_op, cmd_param, cmd_args}, {1'b1, s_op, s_param, s_args});
        end
        @(negedge clk);
        expect_cmd(4'd1, 12'h555, 72'h0, 1'b0);
        cmd_ready = 1'b1;
        #1;
        chk("release_shift_same_cycle", in_shift, 1'b1);
        @(posedge clk);
        nd(1'b1); nd(1'b1);

        // Stream of zero-argument headers: valid on consecutive cycles.
        acc_cyc_q.delete();
        expect_cmd(4'd1, 12'hABC, 72'h0, 1'b0);
        expect_cmd(4'd7, 12'h000, 72'h0, 1'b1);
        expect_cmd(4'd0, 12'h000, 72'h0, 1'b0);
        push_word(16'h1ABC); push_word(16'h7000); push_word(16'h0000);
        nd(1'b1); nd(1'b1); nd(1'b1);
        chk("stream_count", acc_cyc_q.size(), 3);
        if (acc_cyc_q.size() >= 3) begin
            chk("stream_gap01", acc_cyc_q[1] - acc_cyc_q[0], 1);
            chk("stream_gap12", acc_cyc_q[2] - acc_cyc_q[1], 1);
        end

        // LINE with only 2 of 4 arguments, then the FIFO runs dry.
        push_word(16'h3000); push_word(16'h0011); push_word(16'h0022);
        @(negedge clk);
        in_valid = 1'b0;
        pulses = 0; hit = -1;
        for (int i = 1; i <= TMO + 4; i++) begin
            @(posedge clk); #1;
            if (cmd_timeout) begin pulses++; hit = i; end
        end
        chk("starve_valid", cmd_valid, 1'b0);
`ifdef GEO_CMD_TIMEOUT_EN
        chk("timeout_pulses", pulses, 1);
        chk("timeout_cycle", hit, TMO);
        expect_cmd(4'd1, 12'h234, 72'h0, 1'b0);
        push_word(16'h1234);
`else
        chk("no_timeout_pulses", pulses, 0);
        expect_cmd(4'd3, 12'h000, mk_args(12'h011, 12'h022, 12'h033, 12'h044, 0, 0), 1'b0);
        push_word(16'h0033); push_word(16'h0044);
`endif
        nd(1'b1); nd(1'b1);

        // Reset in the middle of argument collection.
        push_word(16'h3000); push_word(16'h0099);
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        expect_cmd(4'd2, 12'hFFF, mk_args(12'hFFF, 12'h234, 0, 0, 0, 0), 1'b0);
        push_word(16'h2FFF); push_word(16'h0FFF); push_word(16'h1234);
        repeat (5) nd(1'b1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/geo_cmd_unpacker.md
# geo_cmd_unpacker

Consumes 16-bit geometry command words from the upstream 2-word FWFT FIFO and assembles each multi-word command (header + 0–6 argument words) into one wide, parallel command for the geometry engine. Sits directly downstream of the FIFO. It drives the FIFO's `shift_out` from its own state and presents finished commands on a valid/ready port.

## Interface
- `COORD_BITS`, 12: width of each stored argument; the low bits of each argument word.
- `TIMEOUT_CYCLES`, 1024: consecutive empty-FIFO cycles that abort a partial command. Used only with the timeout feature.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  FIFO `fifo_not_empty`; `in_data` holds a valid word.
- `in_data`  in  16  FIFO `data_out`.
- `in_shift`  out  1  to FIFO `shift_out`; combinational; consumes `in_data` this cycle.
- `cmd_valid`  out  1  assembled command present.
- `cmd_ready`  in  1  downstream accepts the command when high with `cmd_valid`.
- `cmd_op`  out  4  opcode (header [15:12]).
- `cmd_param`  out  12  header [11:0] (colour/flags).
- `cmd_args`  out  6*COORD_BITS  argument slot k at bits [k*COORD_BITS +: COORD_BITS].
- `cmd_bad`  out  1  opcode is undefined; valid together with `cmd_valid`.
- `cmd_timeout`  out  1  one-cycle pulse when a partial command is dropped.

## Operation
- Argument count by opcode:
  - 0 NOP: 0 arguments.
  - 1 SET_COLOR: 0 arguments.
  - 2 PLOT: 2 arguments (x, y).
  - 3 LINE: 4 arguments.
  - 4 BOX: 4 arguments.
  - 5 TRI: 6 arguments.
  - 6–15: 0 arguments, with `cmd_bad=1`.
- States:
  - IDLE: waiting for a header.
  - ARGS: collecting arguments; the remaining-count counter runs 6..1.
  - OUT: `cmd_valid=1`.
- IDLE, `in_valid=1`:
  - `in_shift=1`; latch op and param; clear all argument slots to 0.
  - Go to ARGS if count>0, else OUT.
- ARGS, `in_valid=1`:
  - `in_shift=1`; store `in_data[COORD_BITS-1:0]` into the next slot, in order 0,1,2…
  - Go to OUT after the last argument.
- OUT:
  - Outputs are held stable while `cmd_ready=0`; `in_shift=0`.
  - On `cmd_ready=1` with `in_valid=1`, the next header is consumed in the same cycle (processed as in IDLE).
  - On `cmd_ready=1` with `in_valid=0`, go to IDLE.
- `in_shift` is never high while `in_valid=0`.
- Unused argument slots read 0.
- Argument word bits above COORD_BITS are ignored; no sign extension.
- Reset values:
  - State IDLE.
  - `in_shift=0` (combinational), `cmd_valid=0`, `cmd_op=0`, `cmd_param=0`, `cmd_args=0`, `cmd_bad=0`, `cmd_timeout=0`.
  - All counters 0.
- Reset mid-command discards the partial command; no output results from it.

## Timing
- A header consumed in cycle N for a 0-argument command gives `cmd_valid` in N+1.
- A k-argument command with words in consecutive cycles N..N+k gives `cmd_valid` in N+k+1.
- Gaps in `in_valid` stall collection without penalty.
- Sustained throughput with `cmd_ready` held high: one word per cycle. A 0-argument command stream yields a `cmd_valid` every cycle.
- `in_shift` depends combinationally on `in_valid`, the state and `cmd_ready`. There is no combinational path from `in_data` to `in_shift`.

## Configuration
- Macro `GEO_CMD_TIMEOUT_EN`, defined:
  - In ARGS, a counter increments on each cycle with `in_valid=0` and clears on each consumed word.
  - When the counter reaches TIMEOUT_CYCLES, the partial command is dropped, state goes to IDLE, and `cmd_timeout` pulses for 1 cycle.
  - The counter clears on entry to ARGS.
- Macro not defined:
  - No counter; ARGS waits indefinitely.
  - `cmd_timeout` is tied 0.

## Test plan
- Reset, then words 0x2123, 0x0010, 0x0020 back-to-back with `cmd_ready=1` -> `cmd_valid` 1 cycle after the last word; op=2, param=0x123, slot0=0x010, slot1=0x020, slots 2–5=0.
- TRI header 0x5000 + 6 arguments 0xF001..0xF006 -> slots = 0x001..0x006 (upper bits stripped); `cmd_bad=0`.
- Hold `cmd_ready=0` for 5 cycles during OUT while the FIFO holds the next header -> outputs stable and `in_shift=0`. Raise `cmd_ready` -> next header consumed in that same cycle.
- Stream of headers 0x1ABC, 0x7000, 0x0000 -> three consecutive `cmd_valid` cycles; the second has `cmd_bad=1`.
- LINE header + 2 arguments, then the FIFO stays empty -> with the macro: `cmd_timeout` pulse exactly TIMEOUT_CYCLES cycles after the last word, then a fresh header decodes correctly. Without the macro: no pulse, and the command completes when the remaining arguments arrive.
- Assert `reset` mid-ARGS -> all outputs 0 immediately; the next header starts a fresh command.
